// File: rtl/pcie_fc_pkg.sv
// Shared definitions for PCIe flow-control gates: FSM states, TLP header field
// offsets and the data-credit unit.
package pcie_fc_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PASS = 1'b1
  } fc_state_e;

  localparam int unsigned HDR_FMT_DATA_BIT = 126;
  localparam int unsigned HDR_LEN_LSB      = 96;
  localparam int unsigned HDR_LEN_MSB      = 105;
  localparam int unsigned CREDIT_DWORDS    = 4;

  localparam int unsigned PH_W      = 9;
  localparam int unsigned PD_W      = 13;
  localparam int unsigned NEED_PD_W = 9;
  localparam int unsigned CMP_W     = 14;

  // Length field of 0 encodes 1024 dwords; result is rounded up to whole credits.
  function automatic logic [NEED_PD_W-1:0] dwords_to_credits(input logic [9:0] len);
    logic [10:0] dw;
    logic [10:0] rnd;
    dw  = (len == 10'd0) ? 11'd1024 : {1'b0, len};
    rnd = (dw + 11'(CREDIT_DWORDS - 1)) / 11'(CREDIT_DWORDS);
    return rnd[NEED_PD_W-1:0];
  endfunction

endpackage

// File: rtl/pcie_fc_credit_calc.sv
// Combinational decoder from TLP header fields to header/data credits needed;
// shared by posted, non-posted and completion gates.
module pcie_fc_credit_calc
  import pcie_fc_pkg::*;
(
  input  logic                 fmt_data,
  input  logic [9:0]           len,
  output logic                 need_ph,
  output logic [NEED_PD_W-1:0] need_pd
);

  always_comb begin
    need_ph = 1'b1;
    need_pd = fmt_data ? dwords_to_credits(len) : '0;
  end

endmodule

// File: rtl/pcie_tlp_fc_gate.sv
// Posted-write TLP gate: holds a packet's sop until the core advertises enough
// credits, accounting for credits issued but not yet reflected. Stall counter
// is built only when PCIE_FC_GATE_STATS_EN is defined.
module pcie_tlp_fc_gate
  import pcie_fc_pkg::*;
#(
  parameter int TLP_SEG_DATA_WIDTH = 256,
  parameter int TLP_SEG_STRB_WIDTH = TLP_SEG_DATA_WIDTH / 32,
  parameter int TLP_SEG_HDR_WIDTH  = 128,
  parameter int TX_SEQ_NUM_WIDTH   = 6,
  parameter int FC_LATENCY         = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,

  input  logic [TLP_SEG_DATA_WIDTH-1:0] s_tlp_data,
  input  logic [TLP_SEG_STRB_WIDTH-1:0] s_tlp_strb,
  input  logic [TLP_SEG_HDR_WIDTH-1:0]  s_tlp_hdr,
  input  logic [TX_SEQ_NUM_WIDTH-1:0]   s_tlp_seq,
  input  logic                          s_tlp_valid,
  input  logic                          s_tlp_sop,
  input  logic                          s_tlp_eop,
  output logic                          s_tlp_ready,

  output logic [TLP_SEG_DATA_WIDTH-1:0] m_tlp_data,
  output logic [TLP_SEG_STRB_WIDTH-1:0] m_tlp_strb,
  output logic [TLP_SEG_HDR_WIDTH-1:0]  m_tlp_hdr,
  output logic [TX_SEQ_NUM_WIDTH-1:0]   m_tlp_seq,
  output logic                          m_tlp_valid,
  output logic                          m_tlp_sop,
  output logic                          m_tlp_eop,
  input  logic                          m_tlp_ready,

  input  logic [7:0]                    tx_fc_ph_av,
  input  logic [11:0]                   tx_fc_pd_av,

  output logic [31:0]                   stat_stall_cycles
);

  fc_state_e             state;
  logic [PH_W-1:0]       pending_ph;
  logic [PD_W-1:0]       pending_pd;
  logic [7:0]            timer;

  logic                  need_ph;
  logic [NEED_PD_W-1:0]  need_pd;
  logic [CMP_W-1:0]      req_ph, req_pd;
  logic                  gate_ok;
  logic                  slot_free;
  logic                  accept;
  logic                  fwd;
  logic                  sop_take;
  logic                  expire;
  logic [PH_W-1:0]       base_ph;
  logic [PD_W-1:0]       base_pd;
  logic [PH_W:0]         sum_ph;
  logic [PD_W:0]         sum_pd;

  pcie_fc_credit_calc u_credit_calc (
    .fmt_data (s_tlp_hdr[HDR_FMT_DATA_BIT]),
    .len      (s_tlp_hdr[HDR_LEN_MSB:HDR_LEN_LSB]),
    .need_ph  (need_ph),
    .need_pd  (need_pd)
  );

  always_comb begin
    req_ph    = CMP_W'(pending_ph) + CMP_W'(need_ph);
    req_pd    = CMP_W'(pending_pd) + CMP_W'(need_pd);
    gate_ok   = (CMP_W'(tx_fc_ph_av) >= req_ph) && (CMP_W'(tx_fc_pd_av) >= req_pd);
    slot_free = !m_tlp_valid || m_tlp_ready;
    // rst_n gates ready directly so upstream sees no acceptance while in reset
    s_tlp_ready = rst_n && slot_free && ((state == ST_PASS) || gate_ok);
    accept    = s_tlp_valid && s_tlp_ready;
    fwd       = accept && ((state == ST_PASS) || s_tlp_sop);
    sop_take  = accept && (state == ST_IDLE) && s_tlp_sop;
    expire    = (timer == 8'd1);
    // Expiry coinciding with a new sop restarts accounting from this TLP alone
    base_ph   = expire ? '0 : pending_ph;
    base_pd   = expire ? '0 : pending_pd;
    sum_ph    = {1'b0, base_ph} + (PH_W + 1)'(need_ph);
    sum_pd    = {1'b0, base_pd} + (PD_W + 1)'(need_pd);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else if (accept) begin
      case (state)
        ST_IDLE: if (s_tlp_sop && !s_tlp_eop) state <= ST_PASS;
        ST_PASS: if (s_tlp_eop) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_ph <= '0;
      pending_pd <= '0;
      timer      <= '0;
    end else begin
      if (sop_take) begin
        pending_ph <= sum_ph[PH_W] ? '1 : sum_ph[PH_W-1:0];
        pending_pd <= sum_pd[PD_W] ? '1 : sum_pd[PD_W-1:0];
        timer      <= 8'(FC_LATENCY);
      end else begin
        if (expire) begin
          pending_ph <= '0;
          pending_pd <= '0;
        end
        if (timer != 8'd0) timer <= timer - 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_tlp_valid <= 1'b0;
    end else if (fwd) begin
      m_tlp_valid <= 1'b1;
    end else if (m_tlp_ready) begin
      m_tlp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (fwd) begin
      m_tlp_data <= s_tlp_data;
      m_tlp_strb <= s_tlp_strb;
      m_tlp_hdr  <= s_tlp_hdr;
      m_tlp_seq  <= s_tlp_seq;
      m_tlp_sop  <= s_tlp_sop;
      m_tlp_eop  <= s_tlp_eop;
    end
  end

`ifdef PCIE_FC_GATE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_stall_cycles <= '0;
    end else if ((state == ST_IDLE) && s_tlp_valid && s_tlp_sop && !gate_ok &&
                 (stat_stall_cycles != '1)) begin
      stat_stall_cycles <= stat_stall_cycles + 32'd1;
    end
  end
`else
  assign stat_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pcie_tlp_fc_gate.sv
// Scoreboard bench for pcie_tlp_fc_gate: a per-cycle reference model predicts
// ready, credit accounting and forwarded beats from directed and random traffic.
module tb_pcie_tlp_fc_gate;

  localparam int DW  = 256;
  localparam int SW  = DW / 32;
  localparam int HW  = 128;
  localparam int QW  = 6;
  localparam int LAT = 16;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic [HW-1:0] hdr;
    logic [QW-1:0] seq;
    logic          sop;
    logic          eop;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] s_tlp_data;
  logic [SW-1:0] s_tlp_strb;
  logic [HW-1:0] s_tlp_hdr;
  logic [QW-1:0] s_tlp_seq;
  logic          s_tlp_valid, s_tlp_sop, s_tlp_eop, s_tlp_ready;
  logic [DW-1:0] m_tlp_data;
  logic [SW-1:0] m_tlp_strb;
  logic [HW-1:0] m_tlp_hdr;
  logic [QW-1:0] m_tlp_seq;
  logic          m_tlp_valid, m_tlp_sop, m_tlp_eop;
  logic          m_tlp_ready;
  logic [7:0]    tx_fc_ph_av;
  logic [11:0]   tx_fc_pd_av;
  logic [31:0]   stat_stall_cycles;

  pcie_tlp_fc_gate #(
    .TLP_SEG_DATA_WIDTH (DW),
    .TLP_SEG_STRB_WIDTH (SW),
    .TLP_SEG_HDR_WIDTH  (HW),
    .TX_SEQ_NUM_WIDTH   (QW),
    .FC_LATENCY         (LAT)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .s_tlp_data        (s_tlp_data),
    .s_tlp_strb        (s_tlp_strb),
    .s_tlp_hdr         (s_tlp_hdr),
    .s_tlp_seq         (s_tlp_seq),
    .s_tlp_valid       (s_tlp_valid),
    .s_tlp_sop         (s_tlp_sop),
    .s_tlp_eop         (s_tlp_eop),
    .s_tlp_ready       (s_tlp_ready),
    .m_tlp_data        (m_tlp_data),
    .m_tlp_strb        (m_tlp_strb),
    .m_tlp_hdr         (m_tlp_hdr),
    .m_tlp_seq         (m_tlp_seq),
    .m_tlp_valid       (m_tlp_valid),
    .m_tlp_sop         (m_tlp_sop),
    .m_tlp_eop         (m_tlp_eop),
    .m_tlp_ready       (m_tlp_ready),
    .tx_fc_ph_av       (tx_fc_ph_av),
    .tx_fc_pd_av       (tx_fc_pd_av),
    .stat_stall_cycles (stat_stall_cycles)
  );

  always #5 clk = ~clk;

  int    n_vec = 0;
  int    n_err = 0;
  beat_t exp_q[$];
  int    mready_mode = 0;

  // Reference state: packet-in-progress flag, credits accumulated since the
  // last accounting window opened, and the cycle the window was (re)opened.
  bit    in_pkt;
  int    acc_ph, acc_pd;
  int    last_sop;
  int    cyc = 0;
  int    stall_cnt;

  task automatic chk(input string nm, input logic [399:0] act, input logic [399:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int need_pd_of(input logic [HW-1:0] h);
    logic [9:0] l;
    int dws;
    l   = h[105:96];
    dws = (l == 10'd0) ? 1024 : int'(l);
    return h[126] ? (dws + 3) / 4 : 0;
  endfunction

  always @(negedge clk) begin
    case (mready_mode)
      0:       m_tlp_ready = 1'b1;
      1:       m_tlp_ready = ~m_tlp_ready;
      default: m_tlp_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor / scoreboard, sampled mid-cycle after all stimulus has settled.
  always begin : monitor
    int    vis_ph, vis_pd, nph, npd;
    bit    gate, slot_free, exp_ready;
    beat_t got, in_b;
    @(negedge clk);
    #2;
    cyc++;
    if (!rst_n) begin
      in_pkt = 0; acc_ph = 0; acc_pd = 0; last_sop = -1000; stall_cnt = 0;
      exp_q.delete();
      chk("rst_ready", s_tlp_ready, 0);
      chk("rst_m_valid", m_tlp_valid, 0);
      chk("rst_pending", {dut.pending_ph, dut.pending_pd}, 0);
      chk("rst_stat", stat_stall_cycles, 0);
    end else begin
      got = '{data: m_tlp_data, strb: m_tlp_strb, hdr: m_tlp_hdr, seq: m_tlp_seq,
              sop: m_tlp_sop, eop: m_tlp_eop};
      chk("m_valid", m_tlp_valid, exp_q.size() != 0);
      slot_free = (exp_q.size() == 0) || m_tlp_ready;
      if (exp_q.size() != 0) begin
        chk("m_beat", got, exp_q[0]);
        if (m_tlp_ready) void'(exp_q.pop_front());
      end

      vis_ph = (cyc - last_sop >= LAT + 1) ? 0 : acc_ph;
      vis_pd = (cyc - last_sop >= LAT + 1) ? 0 : acc_pd;
      chk("pending_ph", dut.pending_ph, vis_ph);
      chk("pending_pd", dut.pending_pd, vis_pd);

      nph  = 1;
      npd  = need_pd_of(s_tlp_hdr);
      gate = (int'(tx_fc_ph_av) >= vis_ph + nph) && (int'(tx_fc_pd_av) >= vis_pd + npd);
      exp_ready = slot_free && (in_pkt || gate);
      chk("s_ready", s_tlp_ready, exp_ready);

`ifdef PCIE_FC_GATE_STATS_EN
      chk("stat_stall", stat_stall_cycles, stall_cnt);
`else
      chk("stat_stall", stat_stall_cycles, 0);
`endif
      if (!in_pkt && s_tlp_valid && s_tlp_sop && !gate) stall_cnt++;

      in_b = '{data: s_tlp_data, strb: s_tlp_strb, hdr: s_tlp_hdr, seq: s_tlp_seq,
               sop: s_tlp_sop, eop: s_tlp_eop};
      if (s_tlp_valid && exp_ready) begin
        if (in_pkt) begin
          exp_q.push_back(in_b);
          if (s_tlp_eop) in_pkt = 0;
        end else if (s_tlp_sop) begin
          exp_q.push_back(in_b);
          if (cyc - last_sop >= LAT) begin
            acc_ph = 0;
            acc_pd = 0;
          end
          acc_ph   = (acc_ph + nph > 511) ? 511 : acc_ph + nph;
          acc_pd   = (acc_pd + npd > 8191) ? 8191 : acc_pd + npd;
          last_sop = cyc;
          if (!s_tlp_eop) in_pkt = 1;
        end
      end
    end
  end

  function automatic logic [HW-1:0] mk_hdr(input bit data, input logic [9:0] len);
    logic [HW-1:0] h;
    for (int i = 0; i < HW / 32; i++) h[i*32 +: 32] = $urandom;
    h[126]    = data;
    h[105:96] = len;
    return h;
  endfunction

  function automatic beat_t mk_beat(input logic [HW-1:0] h, input bit sop, input bit eop);
    beat_t b;
    for (int i = 0; i < DW / 32; i++) b.data[i*32 +: 32] = $urandom;
    b.strb = SW'($urandom);
    b.hdr  = h;
    b.seq  = QW'($urandom);
    b.sop  = sop;
    b.eop  = eop;
    return b;
  endfunction

  // Present a beat at the current negedge and hold it until accepted or budget ends.
  task automatic drive(input beat_t b, input int budget, output bit ok);
    s_tlp_data  = b.data;
    s_tlp_strb  = b.strb;
    s_tlp_hdr   = b.hdr;
    s_tlp_seq   = b.seq;
    s_tlp_sop   = b.sop;
    s_tlp_eop   = b.eop;
    s_tlp_valid = 1'b1;
    ok = 0;
    for (int n = 0; n < budget; n++) begin
      #3;
      if (s_tlp_ready) begin
        @(negedge clk);
        ok = 1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    s_tlp_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_pkt(input logic [HW-1:0] h, input int nb, input int budget, output bit ok);
    bit o;
    ok = 1;
    for (int b = 0; b < nb; b++) begin
      drive(mk_beat(h, b == 0, b == nb - 1), budget, o);
      if (!o) ok = 0;
    end
  endtask

  task automatic drive_robust(input beat_t b);
    bit o;
    drive(b, 40, o);
    if (!o) begin
      tx_fc_ph_av = 8'd255;
      tx_fc_pd_av = 12'd4095;
      drive(b, 40, o);
    end
    chk("rand_accept", o, 1);
  endtask

  initial begin
    bit ok;
    rst_n = 1'b0;
    s_tlp_valid = 0; s_tlp_sop = 0; s_tlp_eop = 0;
    s_tlp_data = '0; s_tlp_strb = '0; s_tlp_hdr = '0; s_tlp_seq = '0;
    m_tlp_ready = 1'b1;
    tx_fc_ph_av = 8'd8;
    tx_fc_pd_av = 12'd64;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // 4-dword write, single beat: one header and one data credit, released later
    send_pkt(mk_hdr(1, 10'd4), 1, 5, ok);
    chk("mwr4_accept", ok, 1);
    idle(20);

    // Data-credit shortage relieved by raising the advertised count
    tx_fc_ph_av = 8'd1;
    tx_fc_pd_av = 12'd2;
    fork
      send_pkt(mk_hdr(1, 10'd16), 1, 50, ok);
      begin repeat (6) @(negedge clk); tx_fc_pd_av = 12'd4; end
    join
    chk("shortage_accept", ok, 1);
    idle(20);

    // Pending accounting: third write waits for the window to expire
    tx_fc_ph_av = 8'd2;
    tx_fc_pd_av = 12'd100;
    for (int i = 0; i < 3; i++) begin
      send_pkt(mk_hdr(1, 10'd1), 1, 40, ok);
      chk("pending_accept", ok, 1);
    end
    idle(20);

    // Backpressure toggling across a 3-beat packet
    tx_fc_ph_av = 8'd8;
    tx_fc_pd_av = 12'd64;
    mready_mode = 1;
    send_pkt(mk_hdr(1, 10'd8), 3, 10, ok);
    chk("bp_accept", ok, 1);
    idle(4);
    mready_mode = 0;
    idle(20);

    // 1024-dword write needs 256 data credits
    tx_fc_pd_av = 12'd255;
    fork
      send_pkt(mk_hdr(1, 10'd0), 1, 30, ok);
      begin repeat (8) @(negedge clk); tx_fc_pd_av = 12'd256; end
    join
    chk("len0_accept", ok, 1);
    idle(20);

    // Reset during beat 2 of a 4-beat packet; trailing beats are stray
    tx_fc_pd_av = 12'd64;
    begin : rst_case
      logic [HW-1:0] h;
      beat_t b;
      h = mk_hdr(1, 10'd12);
      drive(mk_beat(h, 1, 0), 5, ok);
      chk("rst_beat1", ok, 1);
      b = mk_beat(h, 0, 0);
      s_tlp_data = b.data; s_tlp_sop = 0; s_tlp_eop = 0; s_tlp_valid = 1;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      drive(mk_beat(h, 0, 0), 5, ok);
      chk("rst_beat3_drop", ok, 1);
      drive(mk_beat(h, 0, 1), 5, ok);
      chk("rst_beat4_drop", ok, 1);
      send_pkt(mk_hdr(1, 10'd4), 1, 5, ok);
      chk("rst_next_sop", ok, 1);
    end
    idle(20);

    // Random traffic
    for (int p = 0; p < 150; p++) begin
      logic [HW-1:0] h;
      int nb;
      mready_mode = int'($urandom_range(0, 2));
      tx_fc_ph_av = 8'($urandom_range(0, 8));
      tx_fc_pd_av = 12'($urandom_range(0, 300));
      h  = mk_hdr(1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)));
      nb = int'($urandom_range(1, 4));
      if ($urandom_range(0, 7) == 0) drive_robust(mk_beat(h, 0, 1'($urandom_range(0, 1))));
      for (int b = 0; b < nb; b++) drive_robust(mk_beat(h, b == 0, b == nb - 1));
      idle(int'($urandom_range(0, 3)));
    end
    mready_mode = 0;
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pcie_tlp_fc_gate.md
PCIE_TLP_FC_GATE -- requirements
Module: pcie_tlp_fc_gate

Interface
REQ-001 The parameters SHALL be: TLP_SEG_DATA_WIDTH, default 256, TLP payload width; TLP_SEG_STRB_WIDTH, default TLP_SEG_DATA_WIDTH/32, dword strobes; TLP_SEG_HDR_WIDTH, default 128, header width; TX_SEQ_NUM_WIDTH, default 6, sequence tag width; FC_LATENCY, default 16, cycles before the core's credit counts reflect issued TLPs (1..255).
REQ-002 The ports SHALL be: clk, in, 1, sole clock; rst_n, in, 1, reset (one clock; reset is asynchronous and active-low).
REQ-003 The ports SHALL be: s_tlp_data, s_tlp_strb, s_tlp_hdr, s_tlp_seq, in, parameter widths, upstream posted-write TLP beat.
REQ-004 The ports SHALL be: s_tlp_valid, s_tlp_sop, s_tlp_eop, in, 1 each, beat qualifiers; s_tlp_ready, out, 1, upstream accept.
REQ-005 The ports SHALL be: m_tlp_data, m_tlp_strb, m_tlp_hdr, m_tlp_seq, m_tlp_valid, m_tlp_sop, m_tlp_eop, out, matching widths, to the TX write-request input of the PCIe interface adapter; m_tlp_ready, in, 1.
REQ-006 The ports SHALL be: tx_fc_ph_av, in, 8, posted header credits available; tx_fc_pd_av, in, 12, posted data credits available.
REQ-007 The ports SHALL be: stat_stall_cycles, out, 32, count of credit-stall cycles.

Function
REQ-008 Per TLP, need_ph SHALL be 1 and need_pd SHALL be ceil(len/4) when hdr[126]=1, else 0; len=hdr[105:96], with 0 meaning 1024 dwords.
REQ-009 The block SHALL hold pending_ph (9 b) and pending_pd (13 b): credits issued that the core may not yet reflect.
REQ-010 gate_ok SHALL be tx_fc_ph_av >= pending_ph+need_ph AND tx_fc_pd_av >= pending_pd+need_pd, compared zero-extended to 14 b with no wrap.
REQ-011 The FSM SHALL be IDLE to PASS on acceptance of a sop beat without eop; PASS to IDLE on acceptance of an eop beat; a sop+eop beat SHALL stay in IDLE.
REQ-012 In IDLE, s_tlp_ready SHALL be gate_ok AND output-slot-free; in PASS, it SHALL be output-slot-free only (no credit check mid-packet).
REQ-013 Output-slot-free SHALL mean !m_tlp_valid OR m_tlp_ready.
REQ-014 The output SHALL be a single register stage with one-cycle latency, sustaining one beat per cycle when m_tlp_ready=1.
REQ-015 m_tlp_* SHALL hold stable while m_tlp_valid=1 and m_tlp_ready=0.
REQ-016 On sop acceptance, need_ph and need_pd SHALL be added to pending, saturating at all-ones, and a timer SHALL load FC_LATENCY.
REQ-017 The timer SHALL decrement each cycle while non-zero; on reaching 0, both pending counters SHALL clear.
REQ-018 If expiry and a sop acceptance coincide, pending SHALL become need, not pending+need.
REQ-019 A non-sop beat in IDLE SHALL be accepted and dropped (not forwarded, no credit change).
REQ-020 A sop beat in PASS SHALL be forwarded as data; detection is the upstream's responsibility.
REQ-021 stat_stall_cycles SHALL increment, saturating, each cycle in IDLE with s_tlp_valid and s_tlp_sop asserted and gate_ok=0.

Reset
REQ-022 While rst_n=0: FSM SHALL be IDLE; m_tlp_valid, pending_ph, pending_pd, timer and stat_stall_cycles SHALL be 0; s_tlp_ready SHALL be 0; m_tlp data fields SHALL be don't-care.
REQ-023 Reset mid-packet SHALL abandon the packet, and the first post-reset beat SHALL be treated per REQ-019.

Configuration
REQ-024 With macro PCIE_FC_GATE_STATS_EN defined, the stall counter per REQ-021 SHALL be built; undefined, stat_stall_cycles SHALL be constant 0 and no counter logic SHALL exist.

Structure
REQ-025 Package pcie_fc_pkg SHALL hold the FSM state enum, header field offsets (FMT data bit 126, length 105:96), and the credit unit of 4 dwords.
REQ-026 Sub-module pcie_fc_credit_calc SHALL be a combinational header-to-(need_ph, need_pd) decoder, reusable for non-posted and completion gates.

Verification
REQ-027 Credits: ph_av=8, pd_av=64; 4-dword MWr (len=4), sop+eop -> forwarded after 1 cycle; pending_ph=1, pending_pd=1; both clear 16 cycles later.
REQ-028 Shortage: ph_av=1, pd_av=2; MWr len=16 needs 4 data credits -> s_tlp_ready=0 and stall count increments each cycle; raising pd_av to 4 -> accepted next cycle.
REQ-029 Pending: ph_av=2, pd_av=100; three back-to-back 1-dword MWr -> first two pass; third stalls until the timer expires.
REQ-030 Backpressure: 3-beat TLP with m_tlp_ready toggled 1/0 -> output matches input beat-for-beat with no loss or duplication; FSM returns to IDLE after eop.
REQ-031 Len=0 (1024 dwords) with pd_av=255 -> blocked; with pd_av=256 -> passes, pending_pd=256.
REQ-032 Reset: assert rst_n low during beat 2 of a 4-beat TLP -> m_tlp_valid=0 and pending=0; trailing beats are dropped; the next sop is forwarded normally.
